// File: rtl/weight_fetch_ctrl_if.sv
// weight_fetch_ctrl_if: start/done, ROM and weight-stream signals of weight_fetch_ctrl.
// WEIGHT_FETCH_STALL_CNT_EN adds stall_cnt_o.
interface weight_fetch_ctrl_if #(parameter int DEPTH = 3, parameter int WIDTH = 8);
  logic             start_i;
  logic             busy_o;
  logic             done_o;
  logic [DEPTH-1:0] rom_addr_o;
  logic [WIDTH-1:0] rom_data_i;
  logic [WIDTH-1:0] weight_o;
  logic [DEPTH-1:0] index_o;
  logic             last_o;
  logic             valid_o;
  logic             ready_i;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [15:0]      stall_cnt_o;
  modport slave (input start_i, rom_data_i, ready_i,
                 output busy_o, done_o, rom_addr_o, weight_o, index_o, last_o, valid_o, stall_cnt_o);
  modport master (output start_i, rom_data_i, ready_i,
                  input busy_o, done_o, rom_addr_o, weight_o, index_o, last_o, valid_o, stall_cnt_o);
`else
  modport slave (input start_i, rom_data_i, ready_i,
                 output busy_o, done_o, rom_addr_o, weight_o, index_o, last_o, valid_o);
  modport master (output start_i, rom_data_i, ready_i,
                  input busy_o, done_o, rom_addr_o, weight_o, index_o, last_o, valid_o);
`endif
endinterface

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: walks a 1-cycle-latency weight ROM once per start and streams weights via a 2-entry FIFO.
// WEIGHT_FETCH_STALL_CNT_EN adds a saturating stall cycle counter on stall_cnt_o.
module weight_fetch_ctrl #(
  parameter int DEPTH       = 3,
  parameter int WIDTH       = 8,
  parameter int NUM_WEIGHTS = 8
) (
  input logic                clk_i,
  input logic                reset_i,
  weight_fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam int LAST_I = NUM_WEIGHTS - 1;
  localparam logic [DEPTH:0] LAST = LAST_I[DEPTH:0];
  state_t           r_state, w_next;
  logic [DEPTH:0]   r_issue_cnt;
  logic [DEPTH-1:0] r_addr;
  logic             r_inflight, r_done;
  logic [WIDTH-1:0] r_mem_w [2];
  logic [DEPTH-1:0] r_mem_i [2];
  logic [1:0]       r_mem_l;
  logic             r_rd, r_wr;
  logic [1:0]       r_cnt;
  logic             w_start, w_pop, w_issue, w_last_pop, w_in_last;
  assign w_start    = r_state == IDLE && bus.start_i;
  assign w_pop      = r_cnt != 2'd0 && bus.ready_i;
  // credit: FIFO entries plus the word in flight must leave room after this cycle's pop
  assign w_issue    = r_state == FETCH && ({1'b0, r_cnt} + {2'b0, r_inflight} < 3'd2 + {2'b0, w_pop});
  assign w_last_pop = w_pop && r_mem_l[r_rd];
  assign w_in_last  = {1'b0, r_addr} == LAST;
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE  ? (w_start ? FETCH : IDLE) :
             r_state == FETCH ? (w_issue && r_issue_cnt == LAST ? DRAIN : FETCH) :
                                (w_last_pop ? IDLE : DRAIN);
  end
  always_comb begin
    bus.busy_o = r_state != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_issue_cnt <= '0;
      r_addr      <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cnt       <= 2'd0;
      r_mem_w[0]  <= '0;
      r_mem_w[1]  <= '0;
      r_mem_i[0]  <= '0;
      r_mem_i[1]  <= '0;
      r_mem_l     <= 2'b00;
    end else begin
      r_done     <= w_last_pop;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr      <= r_issue_cnt[DEPTH-1:0];
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_start) begin
        r_issue_cnt <= '0;
        r_rd        <= 1'b0;
        r_wr        <= 1'b0;
        r_cnt       <= 2'd0;
      end else begin
        if (r_inflight) begin
          r_mem_w[r_wr] <= bus.rom_data_i;
          r_mem_i[r_wr] <= r_addr;
          r_mem_l[r_wr] <= w_in_last;
          r_wr          <= ~r_wr;
        end
        if (w_pop) r_rd <= ~r_rd;
        r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      end
    end
  end
  assign bus.rom_addr_o = w_issue ? r_issue_cnt[DEPTH-1:0] : r_addr;
  assign bus.valid_o    = r_cnt != 2'd0;
  assign bus.weight_o   = r_mem_w[r_rd];
  assign bus.index_o    = r_mem_i[r_rd];
  assign bus.last_o     = bus.valid_o && r_mem_l[r_rd];
  assign bus.done_o     = r_done;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk_i) begin
    if (reset_i || w_start) r_stall <= '0;
    else if (bus.valid_o && !bus.ready_i && r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
  end
  assign bus.stall_cnt_o = r_stall;
`endif
endmodule
